// File: rtl/dti_uart_pkg.sv
// dti_uart_pkg: shared UART receiver encodings, FSM states and FIFO entry layout
package dti_uart_pkg;
  localparam logic [1:0] DB5 = 2'd0;
  localparam logic [1:0] DB6 = 2'd1;
  localparam logic [1:0] DB7 = 2'd2;
  localparam logic [1:0] DB8 = 2'd3;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_e;
  typedef struct packed {
    logic       parity_err;
    logic       frame_err;
    logic [7:0] data;
  } rx_entry_t;
  function automatic logic [2:0] last_bit(input logic [1:0] db);
    return db == DB5 ? 3'd4 : db == DB6 ? 3'd5 : db == DB7 ? 3'd6 : db == DB8 ? 3'd7 : 3'd7;
  endfunction
endpackage

// File: rtl/dti_uart_sync_fifo.sv
// dti_uart_sync_fifo: show-ahead synchronous FIFO with level count and drop strobe
module dti_uart_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [LW-1:0]    level_o,
  output logic             drop_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [LW-1:0] level_q;
  logic do_push, do_pop;
  assign empty_o = level_q == '0;
  assign full_o = level_q == LW'(DEPTH);
  assign do_pop = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign drop_o = push_i && !do_push;
  assign level_o = level_q;
  assign head_o = empty_o ? '0 : mem_q[rd_q];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q <= '0;
      wr_q <= '0;
      level_q <= '0;
    end else begin
      rd_q <= rd_q + AW'(do_pop);
      wr_q <= wr_q + AW'(do_push);
      level_q <= level_q + LW'(do_push) - LW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end
endmodule

// File: rtl/dti_uart_rx_core.sv
// dti_uart_rx_core: oversampling UART receiver with majority vote, parity/frame checks and receive FIFO
module dti_uart_rx_core
  import dti_uart_pkg::*;
#(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD_RATE = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int RTS_LEVEL = FIFO_DEPTH - 1,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          rx,
  input  logic [1:0]    cfg_data_bits,
  input  logic          cfg_stop_bits,
  input  logic          cfg_parity_en,
  input  logic          cfg_parity_even,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          rd_parity_err,
  output logic          rd_frame_err,
  output logic          rx_empty,
  output logic          rx_full,
  output logic [LW-1:0] rx_level,
  output logic          overrun,
  input  logic          clr_overrun,
  output logic          rts_n
);
  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int CW = $clog2(DIV + 1);
  localparam int SW = $clog2(OVERSAMPLE);
  state_e state_q, state_d;
  logic [1:0] sync_q, vote_q, db_q;
  logic [CW-1:0] cnt_q;
  logic [SW-1:0] smp_q;
  logic [2:0] bit_q;
  logic [7:0] data_q;
  logic prev_q, stop2_q, par_en_q, even_q, perr_q, ferr_q, overrun_q;
  logic rx_s, fall, tick, vote, maj, push, drop;
  rx_entry_t entry, head;
  assign rx_s = sync_q[1];
  assign fall = prev_q && !rx_s;
  assign tick = state_q != IDLE && cnt_q == CW'(DIV - 1);
  assign vote = tick && smp_q == SW'(OVERSAMPLE / 2 + 1);
  assign maj = (vote_q[1] & vote_q[0]) | (vote_q[1] & rx_s) | (vote_q[0] & rx_s);
  assign push = vote && ((state_q == STOP1 && !stop2_q) || state_q == STOP2);
  assign entry = '{parity_err: perr_q, frame_err: !maj || (state_q == STOP2 && ferr_q), data: data_q};
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = fall ? START : IDLE;
      START:   state_d = vote ? (maj ? IDLE : DATA) : START;
      DATA:    state_d = vote && bit_q == last_bit(db_q) ? (par_en_q ? PARITY : STOP1) : DATA;
      PARITY:  state_d = vote ? STOP1 : PARITY;
      STOP1:   state_d = vote ? (stop2_q ? STOP2 : IDLE) : STOP1;
      STOP2:   state_d = vote ? IDLE : STOP2;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
      state_q <= IDLE;
      cnt_q <= '0;
      smp_q <= '0;
      vote_q <= '0;
      bit_q <= '0;
      data_q <= '0;
      db_q <= '0;
      stop2_q <= 1'b0;
      par_en_q <= 1'b0;
      even_q <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], rx};
      prev_q <= rx_s;
      state_q <= state_d;
      cnt_q <= (tick || state_q == IDLE) ? '0 : cnt_q + CW'(1);
      smp_q <= state_q == IDLE ? '0 : tick ? (smp_q == SW'(OVERSAMPLE - 1) ? '0 : smp_q + SW'(1)) : smp_q;
      if (tick && (smp_q == SW'(OVERSAMPLE / 2 - 1) || smp_q == SW'(OVERSAMPLE / 2)))
        vote_q <= {vote_q[0], rx_s};
      if (state_q == START && vote && !maj) begin
        db_q <= cfg_data_bits;
        stop2_q <= cfg_stop_bits;
        par_en_q <= cfg_parity_en;
        even_q <= cfg_parity_even;
        bit_q <= '0;
        data_q <= '0;
        perr_q <= 1'b0;
      end
      if (state_q == DATA && vote) begin
        data_q[bit_q] <= maj;
        bit_q <= bit_q + 3'd1;
      end
      if (state_q == PARITY && vote) perr_q <= (^data_q ^ maj) == even_q;
      if (state_q == STOP1 && vote) ferr_q <= !maj;
      overrun_q <= drop || (overrun_q && !clr_overrun);
    end
  end
  dti_uart_sync_fifo #(.WIDTH($bits(rx_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push),
    .push_data_i (entry),
    .pop_i       (rd_en),
    .head_o      (head),
    .empty_o     (rx_empty),
    .full_o      (rx_full),
    .level_o     (rx_level),
    .drop_o      (drop)
  );
  assign rd_data = head.data;
  assign rd_parity_err = head.parity_err;
  assign rd_frame_err = head.frame_err;
  assign overrun = overrun_q;
  assign rts_n = rx_level >= LW'(RTS_LEVEL);
endmodule
